// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Hazard and stall controller for a 5-stage MIPS pipeline.
//                Drives the PC, IF/ID, ID2EXE and EXE/MEM load enables.
//                It detects RAW and load-use hazards between ID and the
//                EXE/MEM stages, inserts bubbles into ID2EXE and flushes
//                wrong-path instructions on taken branches. It freezes the
//                whole pipe while data memory is busy, and keeps a saturating
//                stall-cycle counter plus a sticky memory-timeout flag.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst               clock, synchronous active-high reset
//    id_src1_i/id_src2_i    ID-stage source registers
//    id_use_src1_i/2_i      ID instruction actually reads the source
//    exe_dest_i, exe_wb_en_i, exe_mem_read_i   producer in EXE
//    mem_dest_i, mem_wb_en_i                   producer in MEM
//    branch_taken_i         branch resolved taken in EXE this cycle
//    mem_busy_i             data memory not ready, pipe must hold
//    pc_write_en_o, ifid_write_en_o, ifid_flush_o,
//    idexe_write_en_o, idexe_bubble_o, exemem_write_en_o   pipe controls
//    mem_timeout_o          sticky timeout error
//    stall_cycles_o         saturating count of cycles with PC held
//    hz_state_o             debug view of FSM state (0 RUN, 1 LU_STALL,
//                           2 MEM_WAIT)
// ============================================================================
module hazard_ctrl #(
    parameter int FORWARD_EN  = 1,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_src1_i,
    input  logic [4:0]       id_src2_i,
    input  logic             id_use_src1_i,
    input  logic             id_use_src2_i,
    input  logic [4:0]       exe_dest_i,
    input  logic             exe_wb_en_i,
    input  logic             exe_mem_read_i,
    input  logic [4:0]       mem_dest_i,
    input  logic             mem_wb_en_i,
    input  logic             branch_taken_i,
    input  logic             mem_busy_i,
    output logic             pc_write_en_o,
    output logic             ifid_write_en_o,
    output logic             ifid_flush_o,
    output logic             idexe_write_en_o,
    output logic             idexe_bubble_o,
    output logic             exemem_write_en_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [1:0]       hz_state_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    // MEM_TIMEOUT is expected to be at least 1.
    localparam int             BW         = $clog2(MEM_TIMEOUT + 1);
    localparam logic [BW-1:0]  C_BUSY_MAX = BW'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    state_t           ret_state_q, ret_state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [BW-1:0]    busy_cnt_q, busy_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic             w_h_exe;
    logic             w_h_mem;
    logic [1:0]       w_stall_len;
    state_t           w_eval_state;

    // Pipe controls before the reset override.
    logic             w_pc_we;
    logic             w_ifid_we;
    logic             w_ifid_flush;
    logic             w_idexe_we;
    logic             w_idexe_bubble;
    logic             w_exemem_we;

    // ------------------------------------------------------------------
    // Hazard detection; register 0 is hard-wired and never hazards.
    // ------------------------------------------------------------------
    assign w_h_exe = exe_wb_en_i && (exe_dest_i != 5'd0) &&
                     ((id_use_src1_i && (id_src1_i == exe_dest_i)) ||
                      (id_use_src2_i && (id_src2_i == exe_dest_i)));

    assign w_h_mem = mem_wb_en_i && (mem_dest_i != 5'd0) &&
                     ((id_use_src1_i && (id_src1_i == mem_dest_i)) ||
                      (id_use_src2_i && (id_src2_i == mem_dest_i)));

    // The register file is write-first, so WB producers never stall.
    generate
        if (FORWARD_EN != 0) begin : g_fwd
            assign w_stall_len = (w_h_exe && exe_mem_read_i) ? 2'd1 : 2'd0;
        end else begin : g_nofwd
            assign w_stall_len = w_h_exe ? 2'd2 : (w_h_mem ? 2'd1 : 2'd0);
        end
    endgenerate

    // On the first non-busy cycle of MEM_WAIT, the saved state's rules
    // apply directly, so the pipe resumes without a dead cycle.
    assign w_eval_state = (state_q == ST_MEM_WAIT) ? ret_state_q : state_q;

    // ------------------------------------------------------------------
    // Next-state and output decode.
    // Priority: mem_busy > branch_taken > hazard.
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        ret_state_d    = ret_state_q;
        cnt_d          = cnt_q;
        w_pc_we        = 1'b1;
        w_ifid_we      = 1'b1;
        w_ifid_flush   = 1'b0;
        w_idexe_we     = 1'b1;
        w_idexe_bubble = 1'b0;
        w_exemem_we    = 1'b1;

        if (mem_busy_i) begin
            // Freeze: everything holds; the remaining stall count is kept.
            w_pc_we     = 1'b0;
            w_ifid_we   = 1'b0;
            w_idexe_we  = 1'b0;
            w_exemem_we = 1'b0;
            state_d     = ST_MEM_WAIT;
            if (state_q != ST_MEM_WAIT) begin
                ret_state_d = state_q;
            end
        end else begin
            case (w_eval_state)
                ST_RUN: begin
                    state_d = ST_RUN;
                    if (branch_taken_i) begin
                        w_ifid_flush   = 1'b1;
                        w_idexe_bubble = 1'b1;
                    end else if (w_stall_len != 2'd0) begin
                        w_pc_we        = 1'b0;
                        w_ifid_we      = 1'b0;
                        w_idexe_bubble = 1'b1;
                        if (w_stall_len == 2'd2) begin
                            cnt_d   = 2'd1;
                            state_d = ST_LU_STALL;
                        end
                    end
                end
                ST_LU_STALL: begin
                    if (branch_taken_i) begin
                        // Branch kills the stalled instruction anyway.
                        w_ifid_flush   = 1'b1;
                        w_idexe_bubble = 1'b1;
                        cnt_d          = 2'd0;
                        state_d        = ST_RUN;
                    end else begin
                        w_pc_we        = 1'b0;
                        w_ifid_we      = 1'b0;
                        w_idexe_bubble = 1'b1;
                        if (cnt_q <= 2'd1) begin
                            cnt_d   = 2'd0;
                            state_d = ST_RUN;
                        end else begin
                            cnt_d   = cnt_q - 2'd1;
                            state_d = ST_LU_STALL;
                        end
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Timeout and performance counter next-state.
    // ------------------------------------------------------------------
    always_comb begin
        busy_cnt_d = '0;
        if (mem_busy_i) begin
            busy_cnt_d = (busy_cnt_q == C_BUSY_MAX) ? C_BUSY_MAX
                                                    : busy_cnt_q + 1'b1;
        end
        mem_timeout_d = mem_timeout_q || (busy_cnt_d == C_BUSY_MAX);

        stall_cycles_d = stall_cycles_q;
        if (!w_pc_we && (stall_cycles_q != C_CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            ret_state_q    <= ST_RUN;
            cnt_q          <= 2'd0;
            busy_cnt_q     <= '0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            ret_state_q    <= ret_state_d;
            cnt_q          <= cnt_d;
            busy_cnt_q     <= busy_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. During reset the pipe holds PC and IF/ID and pushes
    // NOPs downstream so the stages drain to a clean state.
    // ------------------------------------------------------------------
    assign pc_write_en_o     = rst ? 1'b0 : w_pc_we;
    assign ifid_write_en_o   = rst ? 1'b0 : w_ifid_we;
    assign ifid_flush_o      = rst ? 1'b1 : w_ifid_flush;
    assign idexe_write_en_o  = rst ? 1'b1 : w_idexe_we;
    assign idexe_bubble_o    = rst ? 1'b1 : w_idexe_bubble;
    assign exemem_write_en_o = rst ? 1'b1 : w_exemem_we;
    assign mem_timeout_o     = mem_timeout_q;
    assign stall_cycles_o    = stall_cycles_q;
    assign hz_state_o        = state_q;

endmodule
`default_nettype wire
